// File: rtl/enigma_lampboard.sv
// Lampboard output stage for the enigma core: detects fresh keypresses, samples the cipher
// letter after a settle delay, formats it as ASCII in groups and queues it for a byte consumer.

module enigma_lampboard #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned GROUP  = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        restart,
  input  logic [4:0]  key,
  input  logic [4:0]  cipher,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [15:0] letter_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = $clog2(GROUP + 1);

  localparam logic [4:0] NoKey   = 5'd31;
  localparam logic [4:0] LastKey = 5'd25;
  localparam logic [7:0] Space   = 8'h20;

  // ---------------------------------------------------------------------------
  // Press detection
  // ---------------------------------------------------------------------------
  logic [4:0] key_q;
  logic       press;

  assign press = (key <= LastKey) && (key_q == NoKey);

  // ---------------------------------------------------------------------------
  // Settle pipeline: each stage carries a press flag and the key that formed it
  // ---------------------------------------------------------------------------
  logic [SETTLE-1:0] dly_q, dly_d;
  logic [4:0]        press_key_q [SETTLE];
  logic [4:0]        press_key_d [SETTLE];
  logic              capture;

  always_comb begin
    dly_d          = '0;
    dly_d[0]       = press;
    press_key_d[0] = key;
    for (int i = 1; i < SETTLE; i++) begin
      dly_d[i]       = dly_q[i-1];
      press_key_d[i] = press_key_q[i-1];
    end
  end

  // The registered key must still show the pressed letter when the cipher is sampled.
  assign capture = dly_q[SETTLE-1] && (key_q == press_key_q[SETTLE-1]);

  // ---------------------------------------------------------------------------
  // Conversion and grouping
  // ---------------------------------------------------------------------------
  logic [7:0]    ascii;
  logic [GW-1:0] group_cnt_q, group_cnt_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic [15:0]   letter_count_q, letter_count_d;
  logic          wr_en;
  logic [7:0]    wr_byte;

  assign ascii = (cipher <= LastKey) ? (8'h41 + {3'b000, cipher}) : 8'h3F;

  always_comb begin
    group_cnt_d    = group_cnt_q;
    pend_valid_d   = 1'b0;
    pend_byte_d    = pend_byte_q;
    letter_count_d = letter_count_q;
    wr_en          = 1'b0;
    wr_byte        = 8'h00;

    if (pend_valid_q) begin
      wr_en   = 1'b1;
      wr_byte = pend_byte_q;
    end

    if (capture) begin
      letter_count_d = letter_count_q + 16'd1;
      wr_en          = 1'b1;
      if (group_cnt_q == GW'(GROUP)) begin
        // Space goes out now; the letter follows on the next edge.
        wr_byte      = Space;
        pend_valid_d = 1'b1;
        pend_byte_d  = ascii;
        group_cnt_d  = GW'(1);
      end else begin
        wr_byte     = ascii;
        group_cnt_d = group_cnt_q + GW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, pop, push;
  logic          overflow_q, overflow_d;

  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign tx_valid = (count_q != '0);
  assign tx_data  = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign pop      = tx_valid && tx_ready;
  // A full FIFO still takes the write when the head leaves on the same edge.
  assign push     = wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW + 1)'(1);
    end
    if (wr_en && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      key_q          <= NoKey;
      dly_q          <= '0;
      for (int i = 0; i < SETTLE; i++) begin
        press_key_q[i] <= NoKey;
      end
      group_cnt_q    <= '0;
      pend_valid_q   <= 1'b0;
      pend_byte_q    <= 8'h00;
      letter_count_q <= 16'd0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      key_q          <= key;
      dly_q          <= dly_d;
      for (int i = 0; i < SETTLE; i++) begin
        press_key_q[i] <= press_key_d[i];
      end
      group_cnt_q    <= group_cnt_d;
      pend_valid_q   <= pend_valid_d;
      pend_byte_q    <= pend_byte_d;
      letter_count_q <= letter_count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
    end
  end

  assign overflow     = overflow_q;
  assign letter_count = letter_count_q;

endmodule

// File: doc/enigma_lampboard.md
# enigma_lampboard

Output stage directly downstream of `enigma`. It watches the key code driven into the cipher core and detects each fresh keypress. A configurable number of cycles later it samples the core's 5-bit cipher letter and converts it to ASCII. Letters are queued in a FIFO with a space after every GROUP letters (classic 5-letter groups), and the byte stream is presented on a valid/ready port for a UART or display consumer.

## Interface
- DEPTH, 8: FIFO entries; power of 2, ≥4.
- GROUP, 5: letters per group before a space is inserted; ≥1.
- SETTLE, 1: cycles from press detection to cipher sampling; ≥1.
- clk  in  1  rising-edge clock.
- restart  in  1  reset; one clock, asynchronous, active-low.
- key  in  5  key code feeding `enigma`; 0–25 = A–Z, 5'd31 = no key pressed, 26–30 invalid.
- cipher  in  5  `enigma` output letter code.
- tx_data  out  8  ASCII byte at FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data this cycle.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- letter_count  out  16  letters captured since reset, including dropped letters.

## Operation
- key_q registers key every cycle; reset value 5'd31.
- Press: at an edge where key ≤ 25 and key_q == 31.
  - Keys 26–30 never form a press.
  - A held key produces exactly one press.
  - A key held through reset release is a press at the first edge.
- Capture pipeline: press latches the key into press_key and starts a SETTLE-cycle delay.
  - At the edge SETTLE cycles after the press, cipher is sampled only if key still equals press_key.
  - Otherwise the letter is discarded silently; no count, no byte.
- Conversion: cipher 0–25 → 8'h41 + cipher. cipher 26–31 → 8'h3F ('?').
- Grouping: group_cnt (0..GROUP) increments per captured letter.
  - If a capture occurs with group_cnt == GROUP, write 8'h20 that edge, hold the letter in a pending register, and write it the next edge; group_cnt becomes 1.
  - No trailing space is ever emitted.
  - Presses are ≥2 cycles apart because of the release requirement, so the pending write never collides with the next capture.
- FIFO: first-word-fall-through.
  - tx_data = head entry; 8'h00 when empty.
  - Pop when tx_valid && tx_ready.
  - A write while full is accepted only if a pop occurs the same edge; otherwise the byte is dropped and overflow is set.
  - group_cnt and letter_count advance regardless of drops.
- letter_count wraps 16'hFFFF → 0.
- overflow clears only on reset.
- Reset (asserted at any time, including mid-capture or with a space pending): empties the FIFO and clears the pending letter, delay pipeline, group_cnt, letter_count and overflow.
  - Reset outputs: tx_valid=0, tx_data=8'h00, overflow=0, letter_count=0.

## Timing
- Press detected at edge E0; cipher sampled and byte written at edge E0+SETTLE.
- tx_valid rises in the cycle after that edge.
- Latency key→tx_valid = SETTLE+1 cycles, plus 1 when a space precedes the letter.
- Pop and write on the same edge with 1 entry stored: tx_valid stays 1 and tx_data shows the new byte.
- tx_data must remain stable while tx_valid && !tx_ready.
- Full throughput: one byte per cycle out; input limited to one letter per 2 cycles.

## Test plan
- Reset: assert restart=0 mid-capture with the FIFO holding 3 bytes → tx_valid=0, tx_data=8'h00, overflow=0, letter_count=0; no byte appears after release.
- HELLO, tx_ready=1: keys 8,23,2,10,22, each pressed 1 cycle then 31 for 1 cycle, with cipher 7,4,11,11,14 → bytes 48,45,4C,4C,4F; no 20; letter_count=5.
- Grouping: 6 presses with cipher 0..5 → 41,42,43,44,45,20,46; the space is written one edge before 46.
- Held/invalid: key 5 held for 4 cycles → one byte. Key 27 → nothing. Key released to 31 before E0+SETTLE with SETTLE=2 → nothing. cipher 29 → 3F.
- Overflow: tx_ready=0, DEPTH=8, 10 presses with cipher 0..9 → FIFO holds 41,42,43,44,45,20,46,47; overflow=1; letter_count=10. Then tx_ready=1 → exactly those 8 bytes, then tx_valid=0.
- Backpressure: tx_ready toggled every cycle during a 7-letter stream → no byte lost, duplicated or changed while stalled.
